// File: rtl/seq_priority_encoder_if.sv
// Request/index bus of the sequential priority encoder.
// The master side presents request vectors and consumes indices;
// the slave side is the encoder itself.
interface seq_priority_encoder_if #(
    parameter int N = 4,
    parameter int W = 2
);
    logic         en;
    logic [N-1:0] in;
    logic         in_ready;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic [W:0]   count;

    modport master (
        output en, in, out_ready,
        input  in_ready, out, out_valid, out_last, count
    );

    modport slave (
        input  en, in, out_ready,
        output in_ready, out, out_valid, out_last, count
    );
endinterface

// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: captures a multi-hot request vector and
// emits the binary index of each set bit, lowest first, one per
// valid/ready handshake. out/out_last are derived from the next pending
// vector so that they leave the block straight from flops.
module seq_priority_encoder #(
    parameter int N = 4,
    parameter int W = 2
) (
    input logic                  clk,
    input logic                  rst,
    seq_priority_encoder_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [N-1:0] r_pend;
    logic [N-1:0] w_pend_next;
    logic [N-1:0] w_low_bit;
    logic         w_capture;
    logic [W-1:0] r_out;
    logic         r_out_valid;
    logic         r_out_last;
    logic [W:0]   r_count;

    // Index of the lowest set bit; 0 for an empty vector.
    function automatic logic [W-1:0] f_lowest(input logic [N-1:0] v);
        f_lowest = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) f_lowest = W'(i);
        end
    endfunction

    // Number of set bits.
    function automatic logic [W:0] f_popcount(input logic [N-1:0] v);
        f_popcount = '0;
        for (int i = 0; i < N; i++) begin
            f_popcount = f_popcount + (W + 1)'(v[i]);
        end
    endfunction

    // True when exactly one bit is set.
    function automatic logic f_onehot(input logic [N-1:0] v);
        f_onehot = (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    // Next-state and next-pending logic: capture in IDLE, serve one bit per transfer in BUSY.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and a latch is never inferred.
        w_state_next = r_state;
        w_pend_next  = r_pend;
        w_capture    = 1'b0;
        w_low_bit    = r_pend & (~r_pend + N'(1));
        unique case (r_state)
            IDLE: begin
                if (bus.en && (bus.in != '0)) begin
                    w_capture    = 1'b1;
                    w_pend_next  = bus.in;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                // bus.in is not looked at here, so an X on it cannot reach state.
                if (r_out_valid && bus.out_ready) begin
                    w_pend_next = r_pend & ~w_low_bit;
                    if ((r_pend & ~w_low_bit) == '0) w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, pending vector and registered outputs; rst overrides capture and transfer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state     <= IDLE;
            r_pend      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pend      <= w_pend_next;
            r_out_valid <= (w_state_next == BUSY);
            r_out_last  <= f_onehot(w_pend_next);
            // out keeps its last index once the vector is drained.
            if (w_pend_next != '0) r_out <= f_lowest(w_pend_next);
            if (w_capture) r_count <= f_popcount(bus.in);
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.count     = r_count;

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
- Sequential counterpart of the team's 2-to-4 decoder: takes a multi-hot request vector and returns the binary index of every set bit, one index per handshake, lowest index first.
- Sits between request sources (interrupt lines, grant vectors) and consumers that take binary indices.
- Captures a vector, then drains it over a valid/ready output interface.
- Default configuration is a 4-to-2 encoder.

Parameters:
- N, 4, number of request inputs (2..32).
- W, 2, index width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable.
- in  input  N  multi-hot request vector.
- in_ready  output  1  high when a new vector can be captured.
- out  output  W  binary index of the current lowest pending bit.
- out_valid  output  1  out holds a valid index.
- out_last  output  1  current index is the final pending bit of the captured vector.
- out_ready  input  1  consumer accepts out this cycle.
- count  output  W+1  number of set bits in the captured vector, held until the next capture.

Behaviour:
- Reset and clocking:
  - One clock: clk.
  - Reset is synchronous and active-high on rst.
  - rst sampled high at a clk edge clears everything: pend=0, state=IDLE, out=0, out_valid=0, out_last=0, count=0.
  - in_ready is combinational and equals 1 while in reset-cleared IDLE.
- Internal state:
  - Register pend[N-1:0] holds the bits not yet served.
  - State machine has two states, IDLE and BUSY.
  - All outputs except in_ready are registered.
- IDLE:
  - in_ready=1, out_valid=0.
  - If en=1 and in!=0 at a clk edge: pend<=in, count<=popcount(in), go to BUSY.
  - If en=0 or in==0: stay in IDLE; count keeps its previous value.
- BUSY:
  - in_ready=0; in and en are ignored, with no queuing.
  - out_valid=1.
  - out = index of the lowest set bit of pend.
  - out_last=1 exactly when pend has a single set bit.
- Output handshake:
  - A transfer happens on a clk edge where out_valid=1 and out_ready=1.
  - On a transfer, that bit of pend is cleared and out/out_last advance to the next lowest bit on the following cycle.
  - If out_ready=0, out, out_valid and out_last hold stable.
  - A transfer with out_last=1 clears pend and returns to IDLE; out_valid=0 on the next cycle.
  - There is no capture on that same edge; the earliest new capture is one cycle after the final transfer.
- Latency:
  - Capture edge to first out_valid=1: 1 cycle.
  - With out_ready held high, a vector with k set bits drains in k consecutive cycles.
  - Minimum period per vector: k+1 cycles.
- Output registers:
  - out and out_last are computed from the next value of pend, so they are registered and glitch-free.
  - out holds its last value in IDLE, and is 0 after reset.
- Boundary conditions:
  - in=all ones: N transfers, indices 0..N-1 in order, count=N.
  - Single-bit input: one transfer with out_last=1.
  - in=0 with en=1: no capture and no output.
  - rst high mid-drain: the remaining bits are discarded, out_valid=0 and in_ready=1 on the next cycle.
  - rst takes priority over capture and over a transfer in the same cycle.
  - No X propagation from in while BUSY.

Test Plan:
- Reset: assert rst for 2 cycles with in=4'b1111, en=1 -> out_valid=0, out=2'b00, count=0, in_ready=1; no capture occurs during reset.
- Basic drain: en=1, in=4'b1010, out_ready=1 -> next cycle out=2'b01 with out_last=0, following cycle out=2'b11 with out_last=1; count=3'd2; then out_valid=0 and in_ready=1.
- Backpressure: capture in=4'b1111, hold out_ready=0 for 3 cycles -> out=2'b00 stays stable with valid=1; then ready=1 -> sequence 00,01,10,11 with out_last only on 11; count=3'd4.
- Capture blocking: while BUSY on 4'b0011, drive in=4'b0100 with en=1 -> only indices 00 and 01 are produced; 4'b0100 is never emitted unless re-presented after in_ready=1.
- No-capture cases: en=0 with in=4'b0110, or en=1 with in=4'b0000, for 4 cycles -> out_valid stays 0, count unchanged.
- Reset mid-operation: capture 4'b1110, accept index 01, assert rst -> next cycle out_valid=0, pend empty, in_ready=1; a new capture of 4'b1000 then yields out=2'b11 with out_last=1.
